// File: rtl/demux_8_stream.sv
// 8-bit 1-to-2 stream demultiplexer: one valid/ready byte input steered by sel
// into two independent per-destination FIFOs, each with a wrapping delivery counter.
module demux_8_stream #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [7:0]       src,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [7:0]       z0,
  output logic             z0_valid,
  input  logic             z0_ready,
  output logic [7:0]       z1,
  output logic             z1_valid,
  input  logic             z1_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                OCC_W    = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0]  OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [7:0]       r_mem0 [DEPTH];
  logic [7:0]       r_mem1 [DEPTH];
  logic [PTR_W-1:0] r_wr0, r_rd0, r_wr1, r_rd1;
  logic [OCC_W-1:0] r_occ0, r_occ1;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  logic w_valid0, w_valid1;
  logic w_full0, w_full1;
  logic w_pop0, w_pop1;
  logic w_room0, w_room1;
  logic w_push0, w_push1;

  assign w_valid0 = (r_occ0 != '0);
  assign w_valid1 = (r_occ1 != '0);
  assign w_full0  = (r_occ0 == OCC_FULL);
  assign w_full1  = (r_occ1 == OCC_FULL);
  assign w_pop0   = w_valid0 & z0_ready;
  assign w_pop1   = w_valid1 & z1_ready;

  // A full FIFO that is popping this cycle frees the slot the push lands in.
  assign w_room0  = ~w_full0 | w_pop0;
  assign w_room1  = ~w_full1 | w_pop1;
  assign src_ready = sel ? w_room1 : w_room0;

  assign w_push0  = src_valid & src_ready & ~sel;
  assign w_push1  = src_valid & src_ready & sel;

  // NOTE: data storage has no reset; occupancy alone decides validity, and the
  // head byte is masked to zero while empty so stale/unknown contents never leak.
  always_ff @(posedge clk) begin
    if (w_push0) r_mem0[r_wr0] <= src;
    if (w_push1) r_mem1[r_wr1] <= src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr0  <= '0;
      r_rd0  <= '0;
      r_occ0 <= '0;
    end else begin
      if (w_push0) r_wr0 <= r_wr0 + PTR_ONE;
      if (w_pop0)  r_rd0 <= r_rd0 + PTR_ONE;
      case ({w_push0, w_pop0})
        2'b10:   r_occ0 <= r_occ0 + OCC_ONE;
        2'b01:   r_occ0 <= r_occ0 - OCC_ONE;
        default: r_occ0 <= r_occ0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr1  <= '0;
      r_rd1  <= '0;
      r_occ1 <= '0;
    end else begin
      if (w_push1) r_wr1 <= r_wr1 + PTR_ONE;
      if (w_pop1)  r_rd1 <= r_rd1 + PTR_ONE;
      case ({w_push1, w_pop1})
        2'b10:   r_occ1 <= r_occ1 + OCC_ONE;
        2'b01:   r_occ1 <= r_occ1 - OCC_ONE;
        default: r_occ1 <= r_occ1;
      endcase
    end
  end

  // Clear wins over a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_pop0) r_cnt0 <= r_cnt0 + CNT_ONE;
      if (w_pop1) r_cnt1 <= r_cnt1 + CNT_ONE;
    end
  end

  assign z0_valid = w_valid0;
  assign z1_valid = w_valid1;
  assign z0       = w_valid0 ? r_mem0[r_rd0] : 8'h00;
  assign z1       = w_valid1 ? r_mem1[r_rd1] : 8'h00;
  assign cnt0     = r_cnt0;
  assign cnt1     = r_cnt1;

endmodule

// File: tb/tb_demux_8_stream.sv
// Scoreboard bench for demux_8_stream: accepted bytes are queued per destination
// and compared in order as each output handshake occurs.
module tb_demux_8_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel = 1'b0;
  logic [7:0] src = 8'h00;
  logic       src_valid = 1'b0;
  logic       z0_ready = 1'b0;
  logic       z1_ready = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       src_ready, z0_valid, z1_valid;
  logic [7:0] z0, z1, cnt0, cnt1;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] e0, e1;
  logic [7:0] m_cnt0 = 8'h00;
  logic [7:0] m_cnt1 = 8'h00;

  demux_8_stream #(.DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .src(src), .src_valid(src_valid),
    .src_ready(src_ready), .z0(z0), .z0_valid(z0_valid), .z0_ready(z0_ready),
    .z1(z1), .z1_valid(z1_valid), .z1_ready(z1_ready), .cnt_clr(cnt_clr),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Output monitor: sampled mid-cycle, a handshake seen here completes at the next edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (z0_valid && z0_ready) begin
        n_checks++;
        if (exp0.size() == 0) $display("FAIL dst0_order: got %02h, nothing expected", z0);
        else begin
          e0 = exp0.pop_front();
          if (z0 !== e0) $display("FAIL dst0_order: got %02h exp %02h", z0, e0); else n_pass++;
        end
      end
      if (z1_valid && z1_ready) begin
        n_checks++;
        if (exp1.size() == 0) $display("FAIL dst1_order: got %02h, nothing expected", z1);
        else begin
          e1 = exp1.pop_front();
          if (z1 !== e1) $display("FAIL dst1_order: got %02h exp %02h", z1, e1); else n_pass++;
        end
      end
      if (z0_valid !== 1'b1) begin
        n_checks++;
        if (z0 !== 8'h00) $display("FAIL dst0_empty_zero: got %02h exp 00", z0); else n_pass++;
      end
      if (z1_valid !== 1'b1) begin
        n_checks++;
        if (z1 !== 8'h00) $display("FAIL dst1_empty_zero: got %02h exp 00", z1); else n_pass++;
      end
      if (cnt_clr) begin
        m_cnt0 = 8'h00;
        m_cnt1 = 8'h00;
      end else begin
        if (z0_valid && z0_ready) m_cnt0 = m_cnt0 + 8'd1;
        if (z1_valid && z1_ready) m_cnt1 = m_cnt1 + 8'd1;
      end
    end
  end

  // Offer one byte; returns at posedge+1 after the accepting edge.
  task automatic send(input logic s, input logic [7:0] d, output int waits);
    logic done;
    waits = 0;
    done = 1'b0;
    sel = s;
    src = d;
    src_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (src_ready === 1'b1) begin
        if (s) exp1.push_back(d); else exp0.push_back(d);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          n_checks++;
          $display("FAIL send_timeout: byte %02h sel %0d never accepted", d, s);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    src_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (z0 !== 8'h00) $display("FAIL reset_z0: got %02h exp 00", z0); else n_pass++;
    n_checks++; if (z1 !== 8'h00) $display("FAIL reset_z1: got %02h exp 00", z1); else n_pass++;
    n_checks++; if (z0_valid !== 1'b0) $display("FAIL reset_z0_valid: got %b exp 0", z0_valid); else n_pass++;
    n_checks++; if (z1_valid !== 1'b0) $display("FAIL reset_z1_valid: got %b exp 0", z1_valid); else n_pass++;
    n_checks++; if (cnt0 !== 8'h00) $display("FAIL reset_cnt0: got %0d exp 0", cnt0); else n_pass++;
    n_checks++; if (cnt1 !== 8'h00) $display("FAIL reset_cnt1: got %0d exp 0", cnt1); else n_pass++;
    n_checks++; if (src_ready !== 1'b1) $display("FAIL reset_src_ready0: got %b exp 1", src_ready); else n_pass++;
    sel = 1'b1;
    #1;
    n_checks++; if (src_ready !== 1'b1) $display("FAIL reset_src_ready1: got %b exp 1", src_ready); else n_pass++;
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (z0_valid !== 1'b0 || z1_valid !== 1'b0) $display("FAIL idle_valids: got %b%b exp 00", z0_valid, z1_valid); else n_pass++;
    n_checks++; if (cnt0 !== 8'h00 || cnt1 !== 8'h00) $display("FAIL idle_cnts: got %0d/%0d exp 0/0", cnt0, cnt1); else n_pass++;
    n_checks++; if (z0 !== 8'h00 || z1 !== 8'h00) $display("FAIL idle_z: got %02h/%02h exp 00/00", z0, z1); else n_pass++;
  endtask

  task automatic test_routing();
    int w;
    z0_ready = 1'b1;
    z1_ready = 1'b1;
    sel = 1'b0;
    src = 8'hA5;
    src_valid = 1'b1;
    #2;
    n_checks++; if (z0_valid !== 1'b0) $display("FAIL route_no_bypass: z0_valid got %b exp 0", z0_valid); else n_pass++;
    send(1'b0, 8'hA5, w);
    n_checks++; if (z0_valid !== 1'b1 || z0 !== 8'hA5) $display("FAIL route_lat_a5: got %b/%02h exp 1/a5", z0_valid, z0); else n_pass++;
    send(1'b1, 8'h3C, w);
    n_checks++; if (z1_valid !== 1'b1 || z1 !== 8'h3C) $display("FAIL route_lat_3c: got %b/%02h exp 1/3c", z1_valid, z1); else n_pass++;
    n_checks++; if (z0_valid !== 1'b0) $display("FAIL route_z0_drained: got %b exp 0", z0_valid); else n_pass++;
    send(1'b0, 8'h7E, w);
    n_checks++; if (z0_valid !== 1'b1 || z0 !== 8'h7E) $display("FAIL route_lat_7e: got %b/%02h exp 1/7e", z0_valid, z0); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (cnt0 !== 8'd2) $display("FAIL route_cnt0: got %0d exp 2", cnt0); else n_pass++;
    n_checks++; if (cnt1 !== 8'd1) $display("FAIL route_cnt1: got %0d exp 1", cnt1); else n_pass++;
    n_checks++; if (exp0.size() != 0 || exp1.size() != 0) $display("FAIL route_drain: left %0d/%0d exp 0/0", exp0.size(), exp1.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    int w;
    int w33;
    z0_ready = 1'b0;
    z1_ready = 1'b1;
    send(1'b0, 8'h11, w);
    send(1'b0, 8'h22, w);
    send(1'b1, 8'h44, w);
    n_checks++; if (w !== 0) $display("FAIL bp_dst1_immediate: waited %0d exp 0", w); else n_pass++;
    n_checks++; if (z0_valid !== 1'b1 || z0 !== 8'h11) $display("FAIL bp_head: got %b/%02h exp 1/11", z0_valid, z0); else n_pass++;
    fork
      send(1'b0, 8'h33, w33);
      begin
        repeat (3) begin
          @(negedge clk);
          n_checks++; if (src_ready !== 1'b0) $display("FAIL bp_full_ready: got %b exp 0", src_ready); else n_pass++;
        end
        @(posedge clk);
        #1;
        z0_ready = 1'b1;
      end
    join
    n_checks++; if (w33 !== 3) $display("FAIL bp_held_cycles: got %0d exp 3", w33); else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (exp0.size() != 0 || z0_valid !== 1'b0) $display("FAIL bp_drain: left %0d valid %b exp 0/0", exp0.size(), z0_valid); else n_pass++;
    n_checks++; if (cnt0 !== m_cnt0) $display("FAIL bp_cnt0: got %0d exp %0d", cnt0, m_cnt0); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    int w;
    z0_ready = 1'b0;
    send(1'b0, 8'h11, w);
    send(1'b0, 8'h22, w);
    #1;
    n_checks++; if (src_ready !== 1'b0) $display("FAIL fpp_full: src_ready got %b exp 0", src_ready); else n_pass++;
    z0_ready = 1'b1;
    send(1'b0, 8'h55, w);
    n_checks++; if (w !== 0) $display("FAIL fpp_accept: waited %0d exp 0", w); else n_pass++;
    z0_ready = 1'b0;
    #1;
    n_checks++; if (z0_valid !== 1'b1 || z0 !== 8'h22) $display("FAIL fpp_head: got %b/%02h exp 1/22", z0_valid, z0); else n_pass++;
    n_checks++; if (src_ready !== 1'b0) $display("FAIL fpp_still_full: src_ready got %b exp 0", src_ready); else n_pass++;
    z0_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (exp0.size() != 0 || z0_valid !== 1'b0) $display("FAIL fpp_drain: left %0d valid %b exp 0/0", exp0.size(), z0_valid); else n_pass++;
  endtask

  task automatic test_counter_wrap();
    int w;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    n_checks++; if (cnt0 !== 8'h00 || cnt1 !== 8'h00) $display("FAIL cnt_clear: got %0d/%0d exp 0/0", cnt0, cnt1); else n_pass++;
    z1_ready = 1'b1;
    for (int i = 0; i < 257; i++) send(1'b1, 8'(i), w);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (cnt1 !== 8'd1) $display("FAIL cnt_wrap: got %0d exp 1", cnt1); else n_pass++;
    n_checks++; if (cnt1 !== m_cnt1) $display("FAIL cnt_wrap_model: got %0d exp %0d", cnt1, m_cnt1); else n_pass++;
    send(1'b1, 8'h99, w);
    n_checks++; if (z1_valid !== 1'b1) $display("FAIL cnt_clr_setup: z1_valid got %b exp 1", z1_valid); else n_pass++;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    n_checks++; if (cnt1 !== 8'h00) $display("FAIL cnt_clr_priority: got %0d exp 0", cnt1); else n_pass++;
    n_checks++; if (z1_valid !== 1'b0) $display("FAIL cnt_clr_fifo: z1_valid got %b exp 0", z1_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    int w;
    z0_ready = 1'b1;
    send(1'b0, 8'hC3, w);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (cnt0 !== 8'd1 || m_cnt0 !== 8'd1) $display("FAIL ar_pre_cnt0: got %0d model %0d exp 1", cnt0, m_cnt0); else n_pass++;
    z0_ready = 1'b0;
    send(1'b0, 8'hD1, w);
    send(1'b0, 8'hE2, w);
    n_checks++; if (z0_valid !== 1'b1 || z0 !== 8'hD1) $display("FAIL ar_pre_head: got %b/%02h exp 1/d1", z0_valid, z0); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (z0_valid !== 1'b0 || z0 !== 8'h00) $display("FAIL ar_immediate: got %b/%02h exp 0/00", z0_valid, z0); else n_pass++;
    n_checks++; if (cnt0 !== 8'h00) $display("FAIL ar_cnt0: got %0d exp 0", cnt0); else n_pass++;
    exp0.delete();
    exp1.delete();
    m_cnt0 = 8'h00;
    m_cnt1 = 8'h00;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    z0_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (z0_valid !== 1'b0 || z0 !== 8'h00) $display("FAIL ar_post_empty: got %b/%02h exp 0/00", z0_valid, z0); else n_pass++;
    send(1'b0, 8'hF0, w);
    n_checks++; if (z0_valid !== 1'b1 || z0 !== 8'hF0) $display("FAIL ar_resume: got %b/%02h exp 1/f0", z0_valid, z0); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (exp0.size() != 0 || cnt0 !== 8'd1) $display("FAIL ar_final: left %0d cnt0 %0d exp 0/1", exp0.size(), cnt0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_full_push_pop();
    test_counter_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/demux_8_stream.md
Name: demux_8_stream

Overview:
- 8-bit 1-to-2 stream demultiplexer: the routing counterpart of the team's 8-bit 2:1 select mux.
- Takes one byte stream with a valid/ready handshake and steers each byte to destination 0 or 1 according to `sel`.
- Each destination has its own small FIFO and a wrapping count of delivered bytes.
- Sits between an upstream byte producer and two independent consumers in the ALU datapath test fabric.

Parameters:
- DEPTH, 2, entries per destination FIFO (power of two, ≥2).
- CNT_W, 8, width of each delivered-byte counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  1  destination select for the current input byte (0 → dst0, 1 → dst1).
- src  in  8  input byte.
- src_valid  in  1  input byte present.
- src_ready  out  1  demux accepts `src` this cycle.
- z0  out  8  dst0 head byte; 8'h00 when z0_valid=0.
- z0_valid  out  1  dst0 FIFO non-empty.
- z0_ready  in  1  dst0 consumer accepts.
- z1  out  8  dst1 head byte; 8'h00 when z1_valid=0.
- z1_valid  out  1  dst1 FIFO non-empty.
- z1_ready  in  1  dst1 consumer accepts.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt0  out  CNT_W  bytes delivered on dst0, wrapping.
- cnt1  out  CNT_W  bytes delivered on dst1, wrapping.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Both FIFOs empty, pointers 0.
  - z0/z1=0, z0_valid/z1_valid=0, cnt0/cnt1=0.
  - src_ready is combinational: with empty FIFOs it reads 1, but no transfer occurs while rst_n=0.
- Handshakes:
  - Input handshake: src_valid && src_ready.
  - Output handshake N: zN_valid && zN_ready.
- src_ready is combinational, = selected FIFO not full, OR selected FIFO full AND its output handshake occurs this cycle.
  - src_ready depends on sel.
  - src_ready never depends on the non-selected FIFO.
- Protocol rules on the upstream side:
  - While src_valid=1 and src_ready=0, the upstream holds `src` and `sel` stable.
  - The demux does not check this.
- Push: on an input handshake, `src` is written at the tail of FIFO[sel]; that FIFO's count increments.
- Latency: a byte accepted at edge N is visible on zN with zN_valid=1 after edge N (next cycle); there is no same-cycle bypass.
- Pop: on an output handshake the head advances; count decrements.
- Simultaneous push and pop on the same FIFO:
  - Count is unchanged and both pointers advance.
  - This is legal when the FIFO is full: write to the freed slot.
- Pushes to one FIFO and pops from the other are fully independent in the same cycle.
- Ordering:
  - Strict FIFO order within each destination.
  - No ordering guarantee across destinations.
- Full: the FIFO holds DEPTH entries. src_ready=0 for that sel unless it is popping this cycle; nothing is overwritten.
- Empty: zN_valid=0 and zN=8'h00; zN_ready is ignored.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH; full/empty come from a separate occupancy count (0..DEPTH).
- Counters:
  - cntN increments by 1 on each output-N handshake.
  - Wraps from 2^CNT_W−1 to 0.
  - cnt_clr=1 forces both counters to 0 at the next edge; clear has priority over a same-cycle increment.
  - cnt_clr does not affect the FIFOs.
- Reset mid-operation:
  - FIFO contents are discarded and outputs drop to reset values immediately (asynchronously).
  - Bytes in flight are lost.
  - Operation resumes the first edge after rst_n deasserts.
- No X on any output after reset, regardless of uninitialised storage.

Test Plan:
- Reset/idle: hold rst_n=0 → z0=z1=0, valids=0, cnt0=cnt1=0, src_ready=1; release with src_valid=0 → all unchanged.
- Routing: send 8'hA5 (sel=0), 8'h3C (sel=1), 8'h7E (sel=0) with z0_ready=z1_ready=1 →
  - z0 carries A5 then 7E; z1 carries 3C.
  - Each byte appears one cycle after acceptance.
  - cnt0=2, cnt1=1.
- Backpressure/full (DEPTH=2): z0_ready=0, push 8'h11, 8'h22, 8'h33 to sel=0 →
  - src_ready drops after 2 accepts; 33 is held.
  - Meanwhile a push with sel=1 of 8'h44 is accepted immediately.
  - Raise z0_ready → order 11, 22, 33 on z0.
- Simultaneous push/pop on full FIFO: dst0 full with {11,22}, z0_ready=1, push 8'h55 same cycle →
  - Accepted (src_ready=1).
  - Next cycle z0=22, count stays 2.
  - Final z0 sequence 11, 22, 55.
- Counter wrap/clear (CNT_W=8): deliver 257 bytes on dst1 → cnt1=1; assert cnt_clr in the same cycle as a dst1 handshake → cnt1=0 next cycle.
- Async reset mid-stream: dst0 holding 2 bytes, assert rst_n=0 between edges →
  - z0_valid=0 and z0=0 immediately, cnt0=0.
  - After release, dst0 is empty until a new push.
